// File: rtl/pss_generator.sv
// pss_generator
//
// Transmit-side source for the NR primary synchronisation sequence. On a
// start request it emits the 127-sample BPSK PSS for the requested N_id_2
// as an AXI-stream of complex samples {Q, I}. The I component is
// +/-AMPLITUDE and the Q component is always zero.
//
// The sequence is the 7-bit m-sequence x(i+7) = x(i+4) ^ x(i), read out
// with a cyclic shift of 43*N_id_2. The shift is realised by clocking the
// LFSR forward 43*N_id_2 times (SKIP state) before the first beat is sent.
// Because the LFSR period is 127, this gives the same result as a modular
// index into the sequence.
//
// Ports
//   clk_i              clock
//   reset_ni           asynchronous active-low reset
//   start_i            single-cycle request, honoured only while idle
//   N_id_2_i           sector ID sampled with start_i (0..2 valid, 3 rejected)
//   m_axis_out_tdata   sample {Q, I}, both signed two's complement
//   m_axis_out_tvalid  sample valid
//   m_axis_out_tready  downstream ready
//   m_axis_out_tlast   high on sample 126
//   busy_o             high while skipping or sending
//   done_o             one-cycle pulse after the last handshake
//   error_o            one-cycle pulse when start_i arrives with N_id_2_i = 3
module pss_generator #(
    parameter int OUT_DW    = 32,
    parameter int AMPLITUDE = 2 ** (OUT_DW / 2 - 2),
    parameter int PSS_LEN   = 127
) (
    input  logic              clk_i,
    input  logic              reset_ni,
    input  logic              start_i,
    input  logic [1:0]        N_id_2_i,
    output logic [OUT_DW-1:0] m_axis_out_tdata,
    output logic              m_axis_out_tvalid,
    input  logic              m_axis_out_tready,
    output logic              m_axis_out_tlast,
    output logic              busy_o,
    output logic              done_o,
    output logic              error_o
);

    localparam int HALF_DW = OUT_DW / 2;
    localparam int Q_DW    = OUT_DW - HALF_DW;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SKIP = 2'd1;
    localparam logic [1:0] ST_SEND = 2'd2;

    // [x(6)..x(0)] seed; lfsr_q[0] always holds the current output bit x(i)
    localparam logic [6:0] LFSR_INIT = 7'b1110110;
    localparam logic [6:0] LAST_IDX  = 7'(PSS_LEN - 1);

    localparam logic [HALF_DW-1:0] AMP_POS = HALF_DW'(AMPLITUDE);
    localparam logic [HALF_DW-1:0] AMP_NEG = HALF_DW'(-AMPLITUDE);

    logic [1:0] state_q, state_d;
    logic [6:0] lfsr_q, lfsr_d;
    logic [6:0] skip_cnt_q, skip_cnt_d;
    logic [6:0] sample_cnt_q, sample_cnt_d;
    logic       done_q, done_d;
    logic       error_q, error_d;

    logic [6:0] lfsr_next;
    logic [6:0] skip_load;
    logic       handshake;
    logic [HALF_DW-1:0] sample_i;

    // Window shift: the new top bit is x(i+7) = x(i+4) ^ x(i)
    assign lfsr_next = {lfsr_q[4] ^ lfsr_q[0], lfsr_q[6:1]};
    assign handshake = (state_q == ST_SEND) && m_axis_out_tready;

    // Number of LFSR steps to skip for a cyclic shift of 43*N_id_2
    always_comb begin
        skip_load = 7'd0;
        case (N_id_2_i)
            2'd1:    skip_load = 7'd43;
            2'd2:    skip_load = 7'd86;
            default: skip_load = 7'd0;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        lfsr_d       = lfsr_q;
        skip_cnt_d   = skip_cnt_q;
        sample_cnt_d = sample_cnt_q;
        done_d       = 1'b0;
        error_d      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                lfsr_d       = LFSR_INIT;
                skip_cnt_d   = 7'd0;
                sample_cnt_d = 7'd0;
                if (start_i) begin
                    if (N_id_2_i == 2'd3) begin
                        error_d = 1'b1;
                    end else begin
                        skip_cnt_d = skip_load;
                        state_d    = (N_id_2_i == 2'd0) ? ST_SEND : ST_SKIP;
                    end
                end
            end

            // Leave on the last skip step so SEND sees a fully shifted LFSR
            ST_SKIP: begin
                lfsr_d     = lfsr_next;
                skip_cnt_d = skip_cnt_q - 7'd1;
                if (skip_cnt_q == 7'd1) begin
                    state_d = ST_SEND;
                end
            end

            ST_SEND: begin
                if (handshake) begin
                    if (sample_cnt_q == LAST_IDX) begin
                        state_d      = ST_IDLE;
                        done_d       = 1'b1;
                        lfsr_d       = LFSR_INIT;
                        sample_cnt_d = 7'd0;
                    end else begin
                        lfsr_d       = lfsr_next;
                        sample_cnt_d = sample_cnt_q + 7'd1;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q      <= ST_IDLE;
            lfsr_q       <= LFSR_INIT;
            skip_cnt_q   <= 7'd0;
            sample_cnt_q <= 7'd0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            lfsr_q       <= lfsr_d;
            skip_cnt_q   <= skip_cnt_d;
            sample_cnt_q <= sample_cnt_d;
            done_q       <= done_d;
            error_q      <= error_d;
        end
    end

    // Outputs decode directly from flops so reset clears them without a clock.
    // tdata is forced to zero outside SEND so idle/skip cycles show no stale sample.
    assign sample_i          = lfsr_q[0] ? AMP_NEG : AMP_POS;
    assign m_axis_out_tvalid = (state_q == ST_SEND);
    assign m_axis_out_tlast  = (state_q == ST_SEND) && (sample_cnt_q == LAST_IDX);
    assign m_axis_out_tdata  = (state_q == ST_SEND) ? {{Q_DW{1'b0}}, sample_i} : '0;
    assign busy_o            = (state_q != ST_IDLE);
    assign done_o            = done_q;
    assign error_o           = error_q;

endmodule

// File: tb/tb_pss_generator.sv
// tb_pss_generator
//
// Scoreboard bench for pss_generator. Each accepted start pushes the 127
// expected beats of the frame into a queue. These beats come from a reference
// sequence built straight from the m-sequence recurrence with a modular
// index. A monitor pops and compares the queue on every handshake, and it
// checks that tdata and tlast hold steady during stalls. The main thread
// checks frame timing, busy/done/error behaviour, ignored starts,
// back-to-back frames and a mid-frame reset.
module tb_pss_generator;

    localparam int OUT_DW = 32;
    localparam int HALF   = OUT_DW / 2;
    localparam int AMP    = 2 ** (HALF - 2);
    localparam int LEN    = 127;

    typedef struct {
        logic [OUT_DW-1:0] data;
        logic              last;
    } beat_t;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              start;
    logic [1:0]        nid;
    logic              tready;
    logic [OUT_DW-1:0] tdata;
    logic              tvalid;
    logic              tlast;
    logic              busy;
    logic              done;
    logic              error;

    int    vecCount  = 0;
    int    missCount = 0;
    int    cyc       = 0;
    int    hsCount   = 0;
    int    readyMode = 0;
    int    startCycle = 0;
    int    xseq[LEN];
    beat_t expQ[$];
    beat_t monBeat;

    logic              prevStall = 1'b0;
    logic [OUT_DW-1:0] prevData;
    logic              prevLast;

    pss_generator dut (
        .clk_i             (clk),
        .reset_ni          (reset_n),
        .start_i           (start),
        .N_id_2_i          (nid),
        .m_axis_out_tdata  (tdata),
        .m_axis_out_tvalid (tvalid),
        .m_axis_out_tready (tready),
        .m_axis_out_tlast  (tlast),
        .busy_o            (busy),
        .done_o            (done),
        .error_o           (error)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        vecCount++;
        if (actual !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at t=%0t",
                     name, actual, expected, $time);
        end
    endtask

    // d(n) uses x(m) with m = (n + 43*N_id_2) mod 127; x=0 -> +A, x=1 -> -A
    function automatic logic [OUT_DW-1:0] expSample(input int id, input int n);
        int m;
        logic [HALF-1:0] iVal;
        m    = (n + 43 * id) % LEN;
        iVal = (xseq[m] != 0) ? HALF'(-AMP) : HALF'(AMP);
        return {{(OUT_DW - HALF){1'b0}}, iVal};
    endfunction

    task automatic pushExpect(input int id);
        beat_t b;
        for (int n = 0; n < LEN; n++) begin
            b.data = expSample(id, n);
            b.last = (n == LEN - 1);
            expQ.push_back(b);
        end
    endtask

    // Ready driver: always high, or a fair coin each cycle
    initial begin
        tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            tready = (readyMode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
        end
    end

    // Monitor: pops expected beats on each handshake and checks stall stability
    always @(negedge clk) begin
        if (!reset_n) begin
            prevStall = 1'b0;
        end else begin
            if (prevStall) begin
                checkOutput("stall_tvalid", 32'(tvalid), 32'd1);
                checkOutput("stall_tdata", tdata, prevData);
                checkOutput("stall_tlast", 32'(tlast), 32'(prevLast));
            end
            if (tvalid && tready) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpected_beat", 32'(tvalid), 32'd0);
                end else begin
                    monBeat = expQ.pop_front();
                    checkOutput("beat_tdata", tdata, monBeat.data);
                    checkOutput("beat_tlast", 32'(tlast), 32'(monBeat.last));
                end
                hsCount++;
            end
            prevStall = tvalid && !tready;
            prevData  = tdata;
            prevLast  = tlast;
        end
    end

    // Issue a start; with waitFirst = 0 it is driven in the current cycle
    task automatic applyStimulus(input int id, input bit waitFirst);
        if (waitFirst) @(negedge clk);
        start = 1'b1;
        nid   = 2'(id);
        if (id < 3) pushExpect(id);
        hsCount = 0;
        @(posedge clk);
        #1;
        start      = 1'b0;
        nid        = 2'($urandom_range(0, 3));
        startCycle = cyc;
    endtask

    task automatic waitFrame(input int id, input bit inject, input bit checkLatency);
        int   firstValid = -1;
        int   doneCycle  = -1;
        logic busyAtDone = 1'b0;
        logic errSeen    = 1'b0;
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk);
            if (c == 0) checkOutput("busy_after_start", 32'(busy), 32'd1);
            if (tvalid && firstValid < 0) firstValid = cyc;
            if (error) errSeen = 1'b1;
            if (done) begin
                doneCycle  = cyc;
                busyAtDone = busy;
                break;
            end
            if (inject && (c == 3 || c == 50 + 43 * id)) begin
                start = 1'b1;
                nid   = 2'((id + 1) % 3);
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        checkOutput("done_seen", 32'(doneCycle >= 0), 32'd1);
        if (doneCycle >= 0) begin
            checkOutput("busy_at_done", 32'(busyAtDone), 32'd0);
            checkOutput("handshake_count", 32'(hsCount), 32'd127);
            checkOutput("queue_drained", 32'(expQ.size()), 32'd0);
            if (checkLatency)
                checkOutput("done_latency", 32'(doneCycle - startCycle), 32'(43 * id + 127));
        end
        checkOutput("first_valid_latency", 32'(firstValid - startCycle), 32'(43 * id));
        checkOutput("spurious_error", 32'(errSeen), 32'd0);
        expQ.delete();
    endtask

    initial begin
        int id;
        reset_n = 1'b0;
        start   = 1'b0;
        nid     = 2'd0;

        xseq[0] = 0; xseq[1] = 1; xseq[2] = 1; xseq[3] = 0;
        xseq[4] = 1; xseq[5] = 1; xseq[6] = 1;
        for (int i = 0; i + 7 < LEN; i++) xseq[i + 7] = xseq[i + 4] ^ xseq[i];

        repeat (3) @(negedge clk);
        checkOutput("reset_tvalid", 32'(tvalid), 32'd0);
        checkOutput("reset_tlast", 32'(tlast), 32'd0);
        checkOutput("reset_tdata", tdata, 32'd0);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_done", 32'(done), 32'd0);
        checkOutput("reset_error", 32'(error), 32'd0);
        reset_n = 1'b1;

        // Full-rate frames for each sector ID
        readyMode = 0;
        for (int k = 0; k < 3; k++) begin
            applyStimulus(k, 1);
            waitFrame(k, 0, 1);
        end

        // Invalid sector ID is rejected with a single error pulse
        applyStimulus(3, 1);
        @(negedge clk);
        checkOutput("error_pulse", 32'(error), 32'd1);
        checkOutput("error_busy", 32'(busy), 32'd0);
        checkOutput("error_tvalid", 32'(tvalid), 32'd0);
        @(negedge clk);
        checkOutput("error_clears", 32'(error), 32'd0);
        checkOutput("error_busy_after", 32'(busy), 32'd0);
        checkOutput("error_tvalid_after", 32'(tvalid), 32'd0);

        // Random backpressure: fixed IDs, then random IDs
        readyMode = 1;
        for (int k = 0; k < 6; k++) begin
            id = (k < 3) ? k : int'($urandom_range(0, 2));
            applyStimulus(id, 1);
            waitFrame(id, 0, 0);
        end

        // Starts during SKIP/SEND with another ID must be ignored
        readyMode = 0;
        applyStimulus(1, 1);
        waitFrame(1, 1, 1);
        readyMode = 1;
        applyStimulus(2, 1);
        waitFrame(2, 1, 0);

        // Back-to-back frames, each started in the done_o cycle
        readyMode = 0;
        applyStimulus(0, 1);
        waitFrame(0, 0, 1);
        applyStimulus(2, 0);
        waitFrame(2, 0, 1);
        applyStimulus(1, 0);
        waitFrame(1, 0, 1);

        // Mid-frame reset drops outputs without a clock edge
        applyStimulus(0, 1);
        for (int c = 0; c < 500 && hsCount <= 60; c++) @(negedge clk);
        checkOutput("reached_beat_60", 32'(hsCount > 60), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("async_rst_tvalid", 32'(tvalid), 32'd0);
        checkOutput("async_rst_busy", 32'(busy), 32'd0);
        checkOutput("async_rst_tlast", 32'(tlast), 32'd0);
        checkOutput("async_rst_tdata", tdata, 32'd0);
        expQ.delete();
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        applyStimulus(0, 1);
        waitFrame(0, 0, 1);

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
